soc_system_control_signals: RTL
===============================

Name: soc_system_control_signals

Overview:
- Avalon-MM slave output PIO: HPS writes control bits that drive the matrix coprocessor's control inputs, e.g. start and clear strobes.
- Write-side counterpart of the read-only ready/status input PIO on the same lightweight bridge.
- Adds set/clear aliases and hardware auto-clearing pulse bits, so software can issue a fixed-width strobe with one write.

Parameters:
- WIDTH, 4, number of control bits on out_port (1..32).
- PULSE_CYCLES, 1, cycles a pulse-masked bit stays high after being set (>=1).
- RESET_VALUE, 0, reset value of the data register, WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [31:WIDTH] ignored.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  control outputs, driven directly from the data register.
- pulse_active  out  1  high while the pulse timer runs.

Behaviour:
- Reset is asynchronous, active-low, on clock clk.
- Reset values: data=RESET_VALUE, mask=0, readdata=0, state=IDLE, counter=0, pulse_active=0. Reset mid-pulse aborts immediately.
- A write occurs on a clk edge with chipselect=1 and write_n=0. No wait states. No read strobe.
- Address map (wd = writedata[WIDTH-1:0]):
  - 0 DATA: data <= wd.
  - 1 MASK: mask <= wd.
  - 2 SET: data <= data | wd.
  - 3 CLEAR: data <= data & ~wd.
- new_data is data after the write above; it equals data when there is no write.
- rise = new_data & ~data & mask, using the mask value before this edge.
- FSM, IDLE / PULSE, counter width clog2(PULSE_CYCLES+1):
  - Any state, rise!=0: data <= new_data, cnt <= PULSE_CYCLES-1, state <= PULSE. A retrigger reloads the counter.
  - PULSE, rise==0, cnt!=0: data <= new_data, cnt <= cnt-1.
  - PULSE, rise==0, cnt==0: data <= new_data & ~mask, state <= IDLE. Use mask after any same-cycle MASK write. A write landing on the expiry edge is applied, then masked bits are cleared.
  - IDLE, rise==0: data <= new_data.
- Result: a masked bit rising on edge N is high on out_port for exactly PULSE_CYCLES cycles and low after edge N+PULSE_CYCLES, unless retriggered.
- Unmasked bits are never touched by the timer.
- CLEAR or DATA=0 during PULSE drops the bit at once. The timer keeps running, and expiry is harmless.
- Writing an already-set masked bit gives no rise and no retrigger.
- pulse_active = (state==PULSE).
- readdata is registered, 1-cycle latency, updated every cycle from the current address:
  - 0: zero-extended data.
  - 1: zero-extended mask.
  - 2 and 3: 0.

Optional Feature:
- Macro: SOC_SYSTEM_CTRL_READBACK_EN.
- Defined: readdata as above.
- Undefined: write-only PIO. readdata tied to 32'h0 with no readback mux. Writes, FSM and outputs are unchanged.

Decomposition:
- Package soc_system_ctrl_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_SET=2, ADDR_CLEAR=3;
  - state enum {ST_IDLE, ST_PULSE};
  - a counter-width helper function.
- One sub-module, soc_system_ctrl_pulse_timer, holds the FSM and down-counter.
  - Inputs: trigger (|rise), clk, reset_n.
  - Outputs: expire, active.
  - The top level owns the registers and the Avalon decode.

Test Plan (WIDTH=4, PULSE_CYCLES=3, RESET_VALUE=4'b0000):
- Reset, then read addr 0 and addr 1 -> readdata=0, out_port=0000, pulse_active=0; write DATA=4'hA -> out_port=1010 next cycle, readback 0x0000000A.
- Write MASK=0001, then SET=0001 -> out_port[0]=1 for exactly 3 cycles, pulse_active=1 for those 3 cycles, then bit 0=0 and pulse_active=0; bits [3:1] unchanged.
- Start a pulse, retrigger at cycle 2 (CLEAR=0001 then SET=0001) -> bit 0 high for 1 cycle, low 1 cycle, then high 3 cycles from the retrigger.
- DATA=1111 with MASK=0011 -> bits [1:0] auto-clear after 3 cycles giving out_port=1100; SET=1000 landing on the expiry edge -> out_port=1100, bit 3 stays 1.
- Assert reset_n=0 asynchronously mid-pulse -> out_port=0000, readdata=0, pulse_active=0 without waiting for a clk edge.
- Build without SOC_SYSTEM_CTRL_READBACK_EN -> readdata=0 at every address after writes; out_port and pulse behaviour identical to the scenarios above.

Source files
------------

// File: rtl/soc_system_ctrl_pkg.sv
// Shared constants, state encoding and counter sizing for the HPS control-bit PIO.
// Pure declarations: no latency, no flow control.
package soc_system_ctrl_pkg;

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_MASK  = 2'd1;
   localparam logic [1:0] ADDR_SET   = 2'd2;
   localparam logic [1:0] ADDR_CLEAR = 2'd3;

   typedef enum logic {ST_IDLE, ST_PULSE} state_t;

   // Bits needed to hold 0..cycles; never less than one.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/soc_system_ctrl_pulse_timer.sv
// IDLE/PULSE timer: a trigger (re)loads the down-counter, expire fires PULSE_CYCLES edges after the last trigger.
// expire is combinational for the edge that ends the pulse; no backpressure.
module soc_system_ctrl_pulse_timer
   import soc_system_ctrl_pkg::*;
#(
   parameter int PULSE_CYCLES = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic trigger,
   output logic expire,
   output logic active
);

   localparam int            CW   = cnt_width(PULSE_CYCLES);
   localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      expire  = 1'b0;
      if (trigger) begin
         // A retrigger simply restarts the full pulse length.
         state_d = ST_PULSE;
         cnt_d   = LOAD;
      end else if (state_q == ST_PULSE) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end else begin
            expire  = 1'b1;
            state_d = ST_IDLE;
         end
      end
   end

   assign active = (state_q == ST_PULSE);

endmodule

// File: rtl/soc_system_control_signals.sv
// Avalon-MM output PIO with SET/CLEAR aliases and auto-clearing pulse bits; optional readback under SOC_SYSTEM_CTRL_READBACK_EN.
// Writes take effect on the next edge with no wait states; readdata has one cycle of latency; never stalls.
module soc_system_control_signals
   import soc_system_ctrl_pkg::*;
#(
   parameter int               WIDTH        = 4,
   parameter int               PULSE_CYCLES = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port,
   output logic              pulse_active
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] wd, new_data, rise;
   logic             wr, expire;
   logic             unused_wd_hi;

   assign wr           = chipselect & ~write_n;
   assign wd           = writedata[WIDTH-1:0];
   assign unused_wd_hi = ^writedata;

   always_comb begin
      new_data = data_q;
      mask_d   = mask_q;
      if (wr) begin
         case (address)
            ADDR_DATA:  new_data = wd;
            ADDR_MASK:  mask_d   = wd;
            ADDR_SET:   new_data = data_q | wd;
            ADDR_CLEAR: new_data = data_q & ~wd;
            default:    new_data = data_q;
         endcase
      end
   end

   // Rising edges are qualified by the mask held before this edge.
   assign rise   = new_data & ~data_q & mask_q;
   assign data_d = expire ? (new_data & ~mask_d) : new_data;

   soc_system_ctrl_pulse_timer #(
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .trigger (|rise),
      .expire  (expire),
      .active  (pulse_active)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         mask_q <= '0;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
      end
   end

   assign out_port = data_q;

`ifdef SOC_SYSTEM_CTRL_READBACK_EN
   logic [31:0] readdata_q, readdata_d;

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
         ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata_q <= '0;
      else          readdata_q <= readdata_d;
   end

   assign readdata = readdata_q;
`else
   assign readdata = 32'h0;
`endif

endmodule
